// File: rtl/lane_gene_serializer_pkg.sv
// Shared lane package: default widths, valid-mask encodings and a popcount helper.
package lane_gene_serializer_pkg;

   localparam int unsigned GENE_SZ_DEF = 64;
   localparam int unsigned ATTR_SZ_DEF = 8;

   // Valid-mask encodings used by the add-node lane
   localparam logic [2:0] VLD_NONE = 3'b000;
   localparam logic [2:0] VLD_PASS = 3'b001;  // pass-through gene
   localparam logic [2:0] VLD_NODE = 3'b111;  // node plus two connection genes

   function automatic logic [1:0] popcount3(input logic [2:0] m);
      return {1'b0, m[0]} + {1'b0, m[1]} + {1'b0, m[2]};
   endfunction

endpackage

// File: rtl/lane_gene_serializer_packer.sv
// Combinational packer: compacts the valid genes of a beat into slots 0..2 in slot order.
module lane_gene_packer
   import lane_gene_serializer_pkg::*;
#(
   parameter int unsigned GENE_SZ = GENE_SZ_DEF
) (
   input  logic [2:0]         in_valid,
   input  logic [GENE_SZ-1:0] gene_in1,
   input  logic [GENE_SZ-1:0] gene_in2,
   input  logic [GENE_SZ-1:0] gene_in3,
   output logic [GENE_SZ-1:0] slot0,
   output logic [GENE_SZ-1:0] slot1,
   output logic [GENE_SZ-1:0] slot2,
   output logic [1:0]         wr_cnt
);

   // Slots beyond wr_cnt are don't-care; each slot picks the first valid gene not yet used
   always_comb begin
      slot0  = in_valid[0] ? gene_in1 : (in_valid[1] ? gene_in2 : gene_in3);
      slot1  = (in_valid[0] && in_valid[1]) ? gene_in2 : gene_in3;
      slot2  = gene_in3;
      wr_cnt = popcount3(in_valid);
   end

endmodule

// File: rtl/lane_gene_serializer.sv
// Gene serializer: DEPTH-entry FIFO accepting up to 3 genes per beat, emitting 1 per cycle.
module lane_gene_serializer
   import lane_gene_serializer_pkg::*;
#(
   parameter int unsigned GENE_SZ = GENE_SZ_DEF,
   parameter int unsigned ATTR_SZ = ATTR_SZ_DEF,
   parameter int unsigned DEPTH   = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [GENE_SZ-1:0] gene_in1,
   input  logic [GENE_SZ-1:0] gene_in2,
   input  logic [GENE_SZ-1:0] gene_in3,
   input  logic [2:0]         in_valid,
   output logic               in_ready,
   output logic [GENE_SZ-1:0] gene_out,
   output logic               out_valid,
   input  logic               out_ready,
   input  logic               count_clr,
   output logic [ATTR_SZ-1:0] gene_count,
   output logic               overflow
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [GENE_SZ-1:0] mem [DEPTH];
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic [AW:0]        occ;
   logic [GENE_SZ-1:0] slot [3];
   logic [1:0]         wr_cnt;
   logic [1:0]         n_wr;
   logic               wr_beat;
   logic               drop;
   logic               pop;

   lane_gene_packer #(.GENE_SZ(GENE_SZ)) u_packer (
      .in_valid (in_valid),
      .gene_in1 (gene_in1),
      .gene_in2 (gene_in2),
      .gene_in3 (gene_in3),
      .slot0    (slot[0]),
      .slot1    (slot[1]),
      .slot2    (slot[2]),
      .wr_cnt   (wr_cnt)
   );

   assign in_ready  = (occ <= (AW+1)'(DEPTH - 3));
   assign out_valid = (occ != '0);
   assign gene_out  = out_valid ? mem[rd_ptr] : '0;

   assign wr_beat = (in_valid != '0) && in_ready;
   assign drop    = (in_valid != '0) && !in_ready;
   assign pop     = out_valid && out_ready;
   assign n_wr    = wr_beat ? wr_cnt : 2'd0;

   // Storage write: packed genes land in consecutive entries from the write pointer
   always_ff @(posedge clk) begin
      if (wr_beat) begin
         for (int unsigned i = 0; i < 3; i++) begin
            if (i < 32'(wr_cnt))
               mem[wr_ptr + AW'(i)] <= slot[i];
         end
      end
   end

   // Pointer and occupancy bookkeeping; write and pop may both happen in one cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(n_wr);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         occ <= occ + (AW+1)'(n_wr) - (AW+1)'(pop);
      end
   end

   // Delivered-gene counter (saturating) and sticky drop flag; clear wins over updates
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gene_count <= '0;
         overflow   <= 1'b0;
      end else if (count_clr) begin
         gene_count <= '0;
         overflow   <= 1'b0;
      end else begin
         if (pop && (gene_count != '1))
            gene_count <= gene_count + ATTR_SZ'(1);
         if (drop)
            overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_lane_gene_serializer.sv
// Bench for lane_gene_serializer: queue-based reference model plus directed literal checks.
module tb_lane_gene_serializer;
   import lane_gene_serializer_pkg::*;

   localparam int unsigned GW    = 64;
   localparam int unsigned AWD   = 8;
   localparam int unsigned DEPTH = 8;

   logic           clk = 1'b0;
   logic           rst;
   logic [GW-1:0]  gene_in1, gene_in2, gene_in3;
   logic [2:0]     in_valid;
   logic           in_ready;
   logic [GW-1:0]  gene_out;
   logic           out_valid;
   logic           out_ready;
   logic           count_clr;
   logic [AWD-1:0] gene_count;
   logic           overflow;

   int checks = 0;
   int errors = 0;

   lane_gene_serializer #(.GENE_SZ(GW), .ATTR_SZ(AWD), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .gene_in1   (gene_in1),
      .gene_in2   (gene_in2),
      .gene_in3   (gene_in3),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .gene_out   (gene_out),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .count_clr  (count_clr),
      .gene_count (gene_count),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   // Reference model: a gene queue, a saturating delivery count and a sticky drop flag
   logic [GW-1:0] mq[$];
   int unsigned   m_cnt = 0;
   bit            m_ovf = 1'b0;
   bit            m_rdy;

   // Model update at each clock edge (or immediately on reset)
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mq.delete();
         m_cnt = 0;
         m_ovf = 1'b0;
      end else begin
         m_rdy = (mq.size() <= int'(DEPTH) - 3);
         if (out_ready && mq.size() != 0) begin
            void'(mq.pop_front());
            if (m_cnt < (1 << AWD) - 1) m_cnt++;
         end
         if (in_valid != 3'b000) begin
            if (m_rdy) begin
               if (in_valid[0]) mq.push_back(gene_in1);
               if (in_valid[1]) mq.push_back(gene_in2);
               if (in_valid[2]) mq.push_back(gene_in3);
            end else begin
               m_ovf = 1'b1;
            end
         end
         if (count_clr) begin
            m_cnt = 0;
            m_ovf = 1'b0;
         end
      end
   end

   // Every-cycle comparison of DUT outputs against the model
   always @(negedge clk) begin
      chk("in_ready",   64'(in_ready),   64'(mq.size() <= int'(DEPTH) - 3));
      chk("out_valid",  64'(out_valid),  64'(mq.size() != 0));
      if (mq.size() != 0) chk("gene_out", gene_out, mq[0]);
      chk("gene_count", 64'(gene_count), 64'(m_cnt));
      chk("overflow",   64'(overflow),   64'(m_ovf));
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic [GW-1:0] dv [6];
   logic [GW-1:0] seq;
   int            beats;

   initial begin
      rst = 1'b1; in_valid = VLD_NONE; out_ready = 1'b0; count_clr = 1'b0;
      gene_in1 = '0; gene_in2 = '0; gene_in3 = '0;
      cycle(); cycle();
      chk("rst_out_valid",  64'(out_valid),  64'd0);
      chk("rst_gene_out",   gene_out,        64'd0);
      chk("rst_in_ready",   64'(in_ready),   64'd1);
      chk("rst_gene_count", 64'(gene_count), 64'd0);

      // Single pass-through gene, accepted on the first edge after reset release
      rst = 1'b0; in_valid = VLD_PASS; gene_in1 = 64'hA1; out_ready = 1'b1;
      cycle();
      in_valid = VLD_NONE;
      chk("a_valid", 64'(out_valid), 64'd1);
      chk("a_gene",  gene_out,       64'hA1);
      cycle();
      chk("a_count", 64'(gene_count), 64'd1);
      chk("a_empty", 64'(out_valid),  64'd0);

      // Full beat: three genes out on consecutive cycles
      in_valid = VLD_NODE; gene_in1 = 64'hB1; gene_in2 = 64'hB2; gene_in3 = 64'hB3;
      cycle();
      in_valid = VLD_NONE;
      chk("b_gene1", gene_out, 64'hB1);
      cycle();
      chk("b_gene2", gene_out, 64'hB2);
      cycle();
      chk("b_gene3", gene_out, 64'hB3);
      cycle();
      chk("b_empty", 64'(out_valid),  64'd0);
      chk("b_count", 64'(gene_count), 64'd4);

      // Sparse mask 101: slot 2 skipped
      in_valid = 3'b101; gene_in1 = 64'hC1; gene_in2 = 64'hC2; gene_in3 = 64'hC3;
      cycle();
      in_valid = VLD_NONE;
      chk("c_gene1", gene_out, 64'hC1);
      cycle();
      chk("c_gene3", gene_out, 64'hC3);
      cycle();
      chk("c_empty", 64'(out_valid),  64'd0);
      chk("c_count", 64'(gene_count), 64'd6);

      // Fill to 6 with output stalled, then a dropped beat
      dv = '{64'hD1, 64'hD2, 64'hD3, 64'hD4, 64'hD5, 64'hD6};
      out_ready = 1'b0;
      in_valid = VLD_NODE; gene_in1 = dv[0]; gene_in2 = dv[1]; gene_in3 = dv[2];
      cycle();
      chk("d_ready_at3", 64'(in_ready), 64'd1);
      gene_in1 = dv[3]; gene_in2 = dv[4]; gene_in3 = dv[5];
      cycle();
      chk("d_ready_at6", 64'(in_ready), 64'd0);
      in_valid = VLD_PASS; gene_in1 = 64'hE1;
      cycle();
      in_valid = VLD_NONE;
      chk("d_overflow",  64'(overflow), 64'd1);
      chk("d_still6",    64'(in_ready), 64'd0);
      chk("d_stable",    gene_out,      64'hD1);
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         chk("d_drain", gene_out, dv[i]);
         cycle();
      end
      chk("d_empty", 64'(out_valid),  64'd0);
      chk("d_count", 64'(gene_count), 64'd12);

      count_clr = 1'b1;
      cycle();
      count_clr = 1'b0;
      chk("clr_count", 64'(gene_count), 64'd0);
      chk("clr_ovf",   64'(overflow),   64'd0);

      // Streaming with random back-pressure; beats only when in_ready is high
      seq = 64'h1000; beats = 0;
      for (int cyc = 0; cyc < 3000 && beats < 100; cyc++) begin
         out_ready = 1'($urandom_range(0, 1));
         if (in_ready) begin
            in_valid = VLD_NODE;
            gene_in1 = seq; gene_in2 = seq + 1; gene_in3 = seq + 2;
            seq += 3;
            beats++;
         end else begin
            in_valid = VLD_NONE;
         end
         cycle();
      end
      in_valid = VLD_NONE;
      chk("s_beats", 64'(beats), 64'd100);
      out_ready = 1'b1;
      for (int i = 0; i < 20 && out_valid; i++) cycle();
      chk("s_empty", 64'(out_valid),  64'd0);
      chk("s_ovf",   64'(overflow),   64'd0);
      chk("s_sat",   64'(gene_count), 64'd255);

      // Saturated count plus overflow, then count_clr; FIFO contents survive
      out_ready = 1'b0;
      in_valid = VLD_NODE; gene_in1 = 64'hF1; gene_in2 = 64'hF2; gene_in3 = 64'hF3;
      cycle();
      gene_in1 = 64'hF4; gene_in2 = 64'hF5; gene_in3 = 64'hF6;
      cycle();
      in_valid = VLD_PASS; gene_in1 = 64'hF7;
      cycle();
      in_valid = VLD_NONE;
      chk("g_ovf",   64'(overflow),   64'd1);
      chk("g_count", 64'(gene_count), 64'd255);
      count_clr = 1'b1;
      cycle();
      count_clr = 1'b0;
      chk("g_clr_count", 64'(gene_count), 64'd0);
      chk("g_clr_ovf",   64'(overflow),   64'd0);
      chk("g_kept",      gene_out,        64'hF1);

      // Drain two, leaving four buffered, then reset mid-cycle
      out_ready = 1'b1;
      cycle(); cycle();
      out_ready = 1'b0;
      chk("r_head", gene_out, 64'hF3);
      #2;
      rst = 1'b1;
      #1;
      chk("r_out_valid", 64'(out_valid), 64'd0);
      chk("r_gene_out",  gene_out,       64'd0);
      chk("r_in_ready",  64'(in_ready),  64'd1);
      cycle();
      rst = 1'b0;
      in_valid = VLD_PASS; gene_in1 = 64'h5A;
      cycle();
      in_valid = VLD_NONE;
      chk("r_first", gene_out, 64'h5A);
      out_ready = 1'b1;
      cycle();
      chk("r_empty", 64'(out_valid), 64'd0);
      cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/lane_gene_serializer.md
LANE_GENE_SERIALIZER -- requirements
Module: lane_gene_serializer

Interface
REQ-001 Parameter GENE_SZ, default 64, width of one gene word.
REQ-002 Parameter ATTR_SZ, default 8, width of counters and attributes.
REQ-003 Parameter DEPTH, default 8, buffer entries; legal values are powers of two, at least 4.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 gene_in1, gene_in2, gene_in3  input  GENE_SZ each  candidate genes from an add-node lane, in slot order 1, 2, 3.
REQ-007 in_valid  input  3  per-slot valid mask; bit0 marks gene_in1, bit1 gene_in2, bit2 gene_in3.
REQ-008 in_ready  output  1  high when at least 3 buffer entries are free.
REQ-009 gene_out  output  GENE_SZ  serialized gene at the buffer head.
REQ-010 out_valid  output  1  gene_out holds a valid gene.
REQ-011 out_ready  input  1  downstream accepts gene_out this cycle.
REQ-012 count_clr  input  1  synchronous clear of gene_count and overflow.
REQ-013 gene_count  output  ATTR_SZ  genes delivered downstream since the last clear.
REQ-014 overflow  output  1  sticky flag: an input beat was dropped.

Function
REQ-015 The block SHALL act as a DEPTH-entry FIFO that writes 0-3 genes and pops 0-1 gene per cycle.
REQ-016 Write beat: in_valid is nonzero and in_ready is high.
- Valid genes are written in slot order 1, 2, 3, skipping invalid slots.
- Genes land in consecutive entries starting at the write pointer.
- The write pointer advances by popcount(in_valid).
REQ-017 Pop: out_valid && out_ready. The read pointer advances by 1 and gene_count increments.
REQ-018 Pointers SHALL be log2(DEPTH) bits wide and wrap modulo DEPTH.
REQ-019 Occupancy SHALL be a log2(DEPTH)+1-bit register, updated as occupancy + written - popped.
REQ-020 in_ready SHALL equal (occupancy <= DEPTH-3), computed from the registered occupancy.
- A pop in the same cycle does not raise in_ready.
REQ-021 out_valid SHALL equal (occupancy != 0); gene_out SHALL be the head entry.
- Write-to-output latency is 1 cycle: a gene written at edge N is visible after edge N.
- Storage is never bypassed from input to output.
REQ-022 Beat with in_valid nonzero and in_ready low:
- The whole beat is dropped; no partial write occurs.
- overflow is set at the next edge.
- Buffer contents are unchanged, except that a pop in the same cycle still occurs.
REQ-023 in_valid == 3'b000 SHALL write nothing, regardless of gene_in values.
REQ-024 A simultaneous write and pop SHALL both occur in the same cycle.
- Occupancy changes by written-1.
- When occupancy is 0, the pop cannot occur.
REQ-025 gene_count SHALL saturate at 2^ATTR_SZ-1.
REQ-026 count_clr SHALL zero gene_count and overflow at the next edge.
- count_clr takes priority over a same-cycle increment and a same-cycle overflow set.
- FIFO contents are untouched.
REQ-027 gene_out SHALL remain stable while out_valid is high and out_ready is low.

Reset
REQ-028 Asserting rst SHALL immediately zero all of the following:
- pointers and occupancy;
- gene_count and overflow;
- out_valid and gene_out.
- in_ready reads 1 while in reset.
REQ-029 A reset asserted mid-stream SHALL discard all buffered genes; storage contents need not be cleared.
REQ-030 The first write after rst deasserts SHALL be accepted on the first rising edge.

Structure
REQ-031 The GENE_SZ and ATTR_SZ defaults and the valid-mask encodings SHALL live in the shared lane package:
- 3'b001 = pass-through gene.
- 3'b111 = node plus two connection genes.
REQ-032 The block SHALL contain one sub-module, lane_gene_packer, purely combinational. It maps in_valid and the three genes to:
- packed slots 0-2;
- a write count of 0-3.

Verification
REQ-033 After reset, apply in_valid=001 with gene_in1=64'hA1, out_ready=1 -> the next cycle shows out_valid=1, gene_out=64'hA1; the following cycle shows gene_count=1 and out_valid=0.
REQ-034 Apply in_valid=111 with genes B1, B2, B3, out_ready=1 -> gene_out shows B1, B2, B3 on three consecutive cycles; gene_count advances by 3.
REQ-035 Apply in_valid=101 with genes C1, C2, C3 -> only C1 then C3 are output; C2 is never output.
REQ-036 Hold out_ready=0, then send beats 111, 111 -> occupancy reaches 6 and in_ready=0. A third beat of 001 -> overflow=1 and occupancy stays 6. Releasing out_ready drains exactly 6 genes in order.
REQ-037 Stream 111 beats whenever in_ready is high while out_ready toggles randomly, for 100 beats -> the output order matches the input order, pointer wrap-around causes no loss, and overflow stays 0.
REQ-038 Assert rst with 4 genes buffered -> out_valid=0 immediately. Assert count_clr with gene_count=255 and overflow=1 -> both read 0 on the next cycle.
